// File: rtl/mpu_matrix_loader_if.sv
// ---------------------------------------------------------------------------
// mpu_matrix_loader_if
//
// Groups the signals of the MPU matrix loader: the byte-serial element stream
// coming in (in_data/in_valid/in_last/in_ready), the synchronous frame abort
// (flush), and the hand-off of the two assembled operand matrices to the
// arithmetic units (matrix_a/matrix_b/matrices_valid/matrices_ready), plus the
// framing-violation pulse (frame_error).
//
// Modports:
//   master : the side that feeds the stream and consumes the matrices
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface mpu_matrix_loader_if #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int DIM           = 5
);

  localparam int MATRIX_W = ELEMENT_WIDTH * DIM * DIM;

  logic                     flush;
  logic [ELEMENT_WIDTH-1:0] in_data;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic [MATRIX_W-1:0]      matrix_a;
  logic [MATRIX_W-1:0]      matrix_b;
  logic                     matrices_valid;
  logic                     matrices_ready;
  logic                     frame_error;

  modport master (
    output flush,
    output in_data,
    output in_valid,
    output in_last,
    output matrices_ready,
    input  in_ready,
    input  matrix_a,
    input  matrix_b,
    input  matrices_valid,
    input  frame_error
  );

  modport slave (
    input  flush,
    input  in_data,
    input  in_valid,
    input  in_last,
    input  matrices_ready,
    output in_ready,
    output matrix_a,
    output matrix_b,
    output matrices_valid,
    output frame_error
  );

endinterface

// File: rtl/mpu_matrix_loader.sv
// ---------------------------------------------------------------------------
// mpu_matrix_loader
//
// Front end of the MPU datapath. Collects a byte-serial stream of elements
// into two flattened DIM x DIM operand matrices (A first, then B), then holds
// both stable for the arithmetic units until they are taken, and returns to
// loading the next frame.
//
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset (clears state and both matrices)
//   bus      : mpu_matrix_loader_if.slave
//     flush          - synchronous abort of the current frame (highest priority)
//     in_data/in_valid/in_last/in_ready - element stream handshake
//     matrix_a/matrix_b                 - flattened operands, element k at
//                                         [ELEMENT_WIDTH*k +: ELEMENT_WIDTH]
//     matrices_valid/matrices_ready     - operand hand-off
//     frame_error                       - one-cycle framing violation pulse
//
// All outputs come straight from flops. in_ready and matrices_valid are
// registered versions of "next state is not HOLD" / "next state is HOLD",
// so they track the state register exactly while still being flop outputs;
// in_ready additionally stays low while reset_n is asserted.
// ---------------------------------------------------------------------------
module mpu_matrix_loader #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int DIM           = 5
) (
  input logic                 clock,
  input logic                 reset_n,
  mpu_matrix_loader_if.slave  bus
);

  localparam int N_ELEM   = DIM * DIM;
  localparam int MATRIX_W = ELEMENT_WIDTH * N_ELEM;
  localparam int CW       = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  localparam logic [CW-1:0] LAST_IDX  = CW'(N_ELEM - 1);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);
  localparam logic [CW-1:0] COUNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                   state_q,          state_d;
  logic [CW-1:0]            count_q,          count_d;
  logic [MATRIX_W-1:0]      matrix_a_q,       matrix_a_d;
  logic [MATRIX_W-1:0]      matrix_b_q,       matrix_b_d;
  logic                     in_ready_q,       in_ready_d;
  logic                     matrices_valid_q, matrices_valid_d;
  logic                     frame_error_q,    frame_error_d;

  logic                     beat_s;

  // Replace one element of a flattened matrix; element idx occupies
  // bits [ELEMENT_WIDTH*idx +: ELEMENT_WIDTH], so element 0 is the LSB byte.
  function automatic logic [MATRIX_W-1:0] write_element(
    input logic [MATRIX_W-1:0]      mat,
    input logic [CW-1:0]            idx,
    input logic [ELEMENT_WIDTH-1:0] value
  );
    logic [MATRIX_W-1:0] res;
    res = mat;
    res[ELEMENT_WIDTH*int'(idx) +: ELEMENT_WIDTH] = value;
    return res;
  endfunction

  // A beat needs the registered ready, so nothing is taken in HOLD or in the
  // first cycle after reset release.
  assign beat_s = bus.in_valid & in_ready_q;

  // Next-state, element placement and framing checks.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    matrix_a_d    = matrix_a_q;
    matrix_b_d    = matrix_b_q;
    frame_error_d = 1'b0;

    if (bus.flush) begin
      // Abort wins over any beat, hand-off or framing error this cycle;
      // matrix contents are deliberately left untouched.
      state_d = LOAD_A;
      count_d = COUNT_ZERO;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (beat_s) begin
            matrix_a_d = write_element(matrix_a_q, count_q, bus.in_data);
            if (bus.in_last) begin
              // in_last can only legally mark B element N_ELEM-1.
              frame_error_d = 1'b1;
              state_d       = LOAD_A;
              count_d       = COUNT_ZERO;
            end else if (count_q == LAST_IDX) begin
              state_d = LOAD_B;
              count_d = COUNT_ZERO;
            end else begin
              count_d = count_q + COUNT_ONE;
            end
          end else begin
            state_d = LOAD_A;
          end
        end

        LOAD_B: begin
          if (beat_s) begin
            matrix_b_d = write_element(matrix_b_q, count_q, bus.in_data);
            if (count_q == LAST_IDX) begin
              if (bus.in_last) begin
                state_d = HOLD;
                count_d = COUNT_ZERO;
              end else begin
                // Frame overran its final element without in_last.
                frame_error_d = 1'b1;
                state_d       = LOAD_A;
                count_d       = COUNT_ZERO;
              end
            end else if (bus.in_last) begin
              frame_error_d = 1'b1;
              state_d       = LOAD_A;
              count_d       = COUNT_ZERO;
            end else begin
              count_d = count_q + COUNT_ONE;
            end
          end else begin
            state_d = LOAD_B;
          end
        end

        HOLD: begin
          if (bus.matrices_ready) begin
            state_d = LOAD_A;
            count_d = COUNT_ZERO;
          end else begin
            state_d = HOLD;
          end
        end

        default: begin
          state_d = LOAD_A;
          count_d = COUNT_ZERO;
        end
      endcase
    end

    in_ready_d       = (state_d != HOLD);
    matrices_valid_d = (state_d == HOLD);
  end

  // State, counter, matrix storage and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= LOAD_A;
      count_q          <= COUNT_ZERO;
      matrix_a_q       <= {MATRIX_W{1'b0}};
      matrix_b_q       <= {MATRIX_W{1'b0}};
      in_ready_q       <= 1'b0;
      matrices_valid_q <= 1'b0;
      frame_error_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      matrix_a_q       <= matrix_a_d;
      matrix_b_q       <= matrix_b_d;
      in_ready_q       <= in_ready_d;
      matrices_valid_q <= matrices_valid_d;
      frame_error_q    <= frame_error_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.matrix_a       = matrix_a_q;
  assign bus.matrix_b       = matrix_b_q;
  assign bus.matrices_valid = matrices_valid_q;
  assign bus.frame_error    = frame_error_q;

endmodule
